// File: rtl/mmu_mem_burst_master_if.sv
// Signal bundle between the MMU line request/response path, the burst master
// and the external memory controller.
interface mmu_mem_burst_master_if #(
    parameter int PADDR_WIDTH = 40,
    parameter int MASK_WIDTH  = 64
);
    logic                   i_mmu_req_vld;
    logic                   o_mmu_req_rdy;
    logic                   i_mmu_req_wr;
    logic [PADDR_WIDTH-1:0] i_mmu_req_paddr;
    logic [MASK_WIDTH-1:0]  i_mmu_req_mask;
    logic [511:0]           i_mmu_req_wdat;

    logic                   o_mmu_rsp_vld;
    logic                   i_mmu_rsp_rdy;
    logic                   o_mmu_rsp_wr;
    logic                   o_mmu_rsp_err;
    logic [511:0]           o_mmu_rsp_rdat;

    logic                   o_mem_ext_rden;
    logic                   o_mem_ext_wren;
    logic [MASK_WIDTH-1:0]  o_mem_ext_mask;
    logic [2:0]             o_mem_ext_burst;
    logic [PADDR_WIDTH-1:0] o_mem_ext_paddr;
    logic [127:0]           o_mem_ext_wdat;
    logic                   o_mem_ext_burst_start;
    logic                   o_mem_ext_burst_end;
    logic                   o_mem_ext_burst_vld;

    logic                   i_ext_mmu_rd_ack;
    logic                   i_ext_mmu_wr_ack;
    logic [127:0]           i_ext_mmu_rdat;
    logic                   i_ext_mmu_rdy;

    modport master (
        input  i_mmu_req_vld, i_mmu_req_wr, i_mmu_req_paddr, i_mmu_req_mask, i_mmu_req_wdat,
        input  i_mmu_rsp_rdy,
        input  i_ext_mmu_rd_ack, i_ext_mmu_wr_ack, i_ext_mmu_rdat, i_ext_mmu_rdy,
        output o_mmu_req_rdy,
        output o_mmu_rsp_vld, o_mmu_rsp_wr, o_mmu_rsp_err, o_mmu_rsp_rdat,
        output o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_mask, o_mem_ext_burst,
        output o_mem_ext_paddr, o_mem_ext_wdat,
        output o_mem_ext_burst_start, o_mem_ext_burst_end, o_mem_ext_burst_vld
    );

    modport slave (
        output i_mmu_req_vld, i_mmu_req_wr, i_mmu_req_paddr, i_mmu_req_mask, i_mmu_req_wdat,
        output i_mmu_rsp_rdy,
        output i_ext_mmu_rd_ack, i_ext_mmu_wr_ack, i_ext_mmu_rdat, i_ext_mmu_rdy,
        input  o_mmu_req_rdy,
        input  o_mmu_rsp_vld, o_mmu_rsp_wr, o_mmu_rsp_err, o_mmu_rsp_rdat,
        input  o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_mask, o_mem_ext_burst,
        input  o_mem_ext_paddr, o_mem_ext_wdat,
        input  o_mem_ext_burst_start, o_mem_ext_burst_end, o_mem_ext_burst_vld
    );
endinterface

// File: rtl/mmu_mem_burst_master.sv
// MMU-side initiator: turns one 512-bit line request into a 4 x 128-bit memory
// burst, waits for the matching ack (or times out) and returns one response.
module mmu_mem_burst_master #(
    parameter int PADDR_WIDTH = 40,
    parameter int MASK_WIDTH  = 64,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mmu_mem_burst_master_if.master bus
);
    localparam int            TW      = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BURST, WAIT_ACK, RESP} state_t;

    state_t                 state_reg, state_next;
    logic                   wr_reg;
    logic [PADDR_WIDTH-1:0] paddr_reg;
    logic [MASK_WIDTH-1:0]  mask_reg;
    logic [511:0]           wdat_reg;
    logic [1:0]             beat_reg;
    logic [TW-1:0]          tmo_reg;
    logic [127:0]           rdat_sh_reg [3];
    logic                   rsp_vld_reg, rsp_wr_reg, rsp_err_reg;
    logic [511:0]           rsp_rdat_reg;

    logic                   accept, ack_ok, tmo_hit;
    logic                   req_rdy, in_burst, addr_hold;
    logic [127:0]           wbeat [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_wbeat
        assign wbeat[gi] = wdat_reg[gi*128 +: 128];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        ack_ok     = 1'b0;
        tmo_hit    = 1'b0;
        req_rdy    = 1'b0;
        in_burst   = 1'b0;
        addr_hold  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_rdy = bus.i_ext_mmu_rdy;
                if (bus.i_mmu_req_vld && bus.i_ext_mmu_rdy) begin
                    accept     = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                in_burst  = 1'b1;
                addr_hold = 1'b1;
                if (beat_reg == 2'd3) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                addr_hold = 1'b1;
                // Only the ack type matching the pending op counts.
                ack_ok    = wr_reg ? bus.i_ext_mmu_wr_ack : bus.i_ext_mmu_rd_ack;
                tmo_hit   = (tmo_reg == TO_LAST);
                if (ack_ok || tmo_hit) state_next = RESP;
            end
            RESP: begin
                if (bus.i_mmu_rsp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg         <= 1'b0;
            paddr_reg      <= '0;
            mask_reg       <= '0;
            wdat_reg       <= '0;
            beat_reg       <= 2'd0;
            tmo_reg        <= '0;
            rdat_sh_reg[0] <= '0;
            rdat_sh_reg[1] <= '0;
            rdat_sh_reg[2] <= '0;
            rsp_vld_reg    <= 1'b0;
            rsp_wr_reg     <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_rdat_reg   <= '0;
        end else begin
            // Free-running history so beats arriving before WAIT_ACK are kept.
            rdat_sh_reg[0] <= rdat_sh_reg[1];
            rdat_sh_reg[1] <= rdat_sh_reg[2];
            rdat_sh_reg[2] <= bus.i_ext_mmu_rdat;
            if (accept) begin
                wr_reg    <= bus.i_mmu_req_wr;
                paddr_reg <= bus.i_mmu_req_paddr;
                mask_reg  <= bus.i_mmu_req_mask;
                wdat_reg  <= bus.i_mmu_req_wdat;
                beat_reg  <= 2'd0;
            end
            if (state_reg == BURST) begin
                beat_reg <= beat_reg + 2'd1;
                if (beat_reg == 2'd3) tmo_reg <= '0;
            end
            if (state_reg == WAIT_ACK) begin
                tmo_reg <= tmo_reg + 1'b1;
                if (ack_ok || tmo_hit) begin
                    rsp_vld_reg  <= 1'b1;
                    rsp_wr_reg   <= wr_reg;
                    rsp_err_reg  <= ~ack_ok;
                    rsp_rdat_reg <= (ack_ok && !wr_reg)
                                  ? {bus.i_ext_mmu_rdat, rdat_sh_reg[2], rdat_sh_reg[1], rdat_sh_reg[0]}
                                  : '0;
                end
            end
            if (state_reg == RESP && bus.i_mmu_rsp_rdy) rsp_vld_reg <= 1'b0;
        end
    end

    assign bus.o_mmu_req_rdy         = req_rdy;
    assign bus.o_mmu_rsp_vld         = rsp_vld_reg;
    assign bus.o_mmu_rsp_wr          = rsp_wr_reg;
    assign bus.o_mmu_rsp_err         = rsp_err_reg;
    assign bus.o_mmu_rsp_rdat        = rsp_rdat_reg;
    assign bus.o_mem_ext_burst_vld   = in_burst;
    assign bus.o_mem_ext_burst_start = in_burst && (beat_reg == 2'd0);
    assign bus.o_mem_ext_burst_end   = in_burst && (beat_reg == 2'd3);
    assign bus.o_mem_ext_wren        = in_burst && wr_reg && (beat_reg == 2'd0);
    assign bus.o_mem_ext_rden        = in_burst && !wr_reg && (beat_reg == 2'd0);
    assign bus.o_mem_ext_burst       = in_burst ? 3'b011 : 3'b000;
    assign bus.o_mem_ext_wdat        = (in_burst && wr_reg) ? wbeat[beat_reg] : '0;
    assign bus.o_mem_ext_paddr       = addr_hold ? paddr_reg : '0;
    assign bus.o_mem_ext_mask        = addr_hold ? mask_reg : '0;
endmodule

// File: tb/tb_mmu_mem_burst_master.sv
// Randomized bench for mmu_mem_burst_master against a transaction-level model
// of the line -> 4-beat burst -> ack -> response flow.
module tb_mmu_mem_burst_master;
    localparam int PW = 40;
    localparam int MW = 64;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mmu_mem_burst_master_if #(.PADDR_WIDTH(PW), .MASK_WIDTH(MW)) bus ();

    mmu_mem_burst_master #(.PADDR_WIDTH(PW), .MASK_WIDTH(MW), .ACK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] hist [$];

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Each cycle the responder presents a fresh random read beat; the model
    // remembers the last four so a read line is "the four beats up to the ack".
    task automatic next_cycle();
        logic [127:0] b;
        b = rand128();
        bus.i_ext_mmu_rdat = b;
        hist.push_back(b);
        if (hist.size() > 4) void'(hist.pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_mem_zero(input string tag);
        check_val(tag, {bus.o_mem_ext_burst_vld, bus.o_mem_ext_burst_start, bus.o_mem_ext_burst_end,
                        bus.o_mem_ext_wren, bus.o_mem_ext_rden, bus.o_mem_ext_burst,
                        bus.o_mem_ext_paddr, bus.o_mem_ext_mask, bus.o_mem_ext_wdat}, '0);
    endtask

    task automatic run_txn(input logic wr, input logic [PW-1:0] pa, input logic [MW-1:0] mk,
                           input logic [511:0] wd, input int ack_dly, input int rdy_lo,
                           input int bp, input bit stray);
        logic [511:0] exp_rdat;
        logic         exp_err;
        bit           done;
        bit           match;
        bus.i_mmu_req_vld   = 1'b1;
        bus.i_mmu_req_wr    = wr;
        bus.i_mmu_req_paddr = pa;
        bus.i_mmu_req_mask  = mk;
        bus.i_mmu_req_wdat  = wd;
        bus.i_ext_mmu_rdy   = 1'b0;
        for (int i = 0; i < rdy_lo; i++) begin
            #1;
            check_val("gate_req_rdy", bus.o_mmu_req_rdy, 0);
            check_val("gate_no_burst", bus.o_mem_ext_burst_vld, 0);
            next_cycle();
        end
        bus.i_ext_mmu_rdy = 1'b1;
        #1;
        check_val("idle_req_rdy", bus.o_mmu_req_rdy, 1);
        next_cycle();
        bus.i_mmu_req_vld   = 1'b0;
        bus.i_mmu_req_wr    = ~wr;
        bus.i_mmu_req_paddr = PW'({$urandom, $urandom});
        bus.i_mmu_req_wdat  = {4{rand128()}};
        for (int k = 0; k < 4; k++) begin
            check_val("b_vld",   bus.o_mem_ext_burst_vld, 1);
            check_val("b_start", bus.o_mem_ext_burst_start, (k == 0));
            check_val("b_end",   bus.o_mem_ext_burst_end, (k == 3));
            check_val("b_wren",  bus.o_mem_ext_wren, (wr && k == 0));
            check_val("b_rden",  bus.o_mem_ext_rden, (!wr && k == 0));
            check_val("b_len",   bus.o_mem_ext_burst, 3'b011);
            check_val("b_wdat",  bus.o_mem_ext_wdat, wr ? wd[k*128 +: 128] : 128'd0);
            check_val("b_paddr", bus.o_mem_ext_paddr, pa);
            check_val("b_mask",  bus.o_mem_ext_mask, mk);
            check_val("b_req_rdy", bus.o_mmu_req_rdy, 0);
            bus.i_ext_mmu_rdy    = 1'($urandom);
            bus.i_ext_mmu_rd_ack = stray && ($urandom_range(0, 3) == 0);
            bus.i_ext_mmu_wr_ack = stray && ($urandom_range(0, 3) == 0);
            next_cycle();
        end
        done     = 0;
        exp_err  = 0;
        exp_rdat = '0;
        for (int i = 0; !done; i++) begin
            check_val("w_no_burst", bus.o_mem_ext_burst_vld, 0);
            check_val("w_paddr", bus.o_mem_ext_paddr, pa);
            check_val("w_mask",  bus.o_mem_ext_mask, mk);
            check_val("w_rsp_vld", bus.o_mmu_rsp_vld, 0);
            check_val("w_req_rdy", bus.o_mmu_req_rdy, 0);
            match = (i == ack_dly);
            bus.i_ext_mmu_wr_ack = wr ? match : (stray && ($urandom_range(0, 1) == 0));
            bus.i_ext_mmu_rd_ack = wr ? (stray && ($urandom_range(0, 1) == 0)) : match;
            if (match) done = 1;
            else if (i == TO - 1) begin
                done    = 1;
                exp_err = 1;
            end
            next_cycle();
            if (match && !wr) exp_rdat = {hist[3], hist[2], hist[1], hist[0]};
        end
        bus.i_ext_mmu_wr_ack = 1'b0;
        bus.i_ext_mmu_rd_ack = 1'b0;
        for (int j = 0; j <= bp; j++) begin
            #1;
            check_val("r_vld",  bus.o_mmu_rsp_vld, 1);
            check_val("r_wr",   bus.o_mmu_rsp_wr, wr);
            check_val("r_err",  bus.o_mmu_rsp_err, exp_err);
            check_val("r_rdat", bus.o_mmu_rsp_rdat, exp_rdat);
            check_val("r_req_rdy", bus.o_mmu_req_rdy, 0);
            check_mem_zero("r_mem_zero");
            if (j < bp) begin
                bus.i_ext_mmu_rdy    = 1'($urandom);
                bus.i_ext_mmu_rd_ack = stray && ($urandom_range(0, 2) == 0);
                bus.i_ext_mmu_wr_ack = stray && ($urandom_range(0, 2) == 0);
                next_cycle();
            end
        end
        bus.i_ext_mmu_rd_ack = 1'b0;
        bus.i_ext_mmu_wr_ack = 1'b0;
        bus.i_mmu_rsp_rdy    = 1'b1;
        next_cycle();
        bus.i_mmu_rsp_rdy = 1'b0;
        check_val("hs_rsp_vld", bus.o_mmu_rsp_vld, 0);
        $display("[TB] txn wr=%0d paddr=%0h ack_dly=%0d err=%0d", wr, pa, ack_dly, exp_err);
    endtask

    initial begin
        logic [511:0] line;
        rst_n                = 1'b1;
        bus.i_mmu_req_vld    = 1'b0;
        bus.i_mmu_req_wr     = 1'b0;
        bus.i_mmu_req_paddr  = '0;
        bus.i_mmu_req_mask   = '0;
        bus.i_mmu_req_wdat   = '0;
        bus.i_mmu_rsp_rdy    = 1'b0;
        bus.i_ext_mmu_rd_ack = 1'b0;
        bus.i_ext_mmu_wr_ack = 1'b0;
        bus.i_ext_mmu_rdat   = '0;
        bus.i_ext_mmu_rdy    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_mem_zero("rst_mem_zero");
        check_val("rst_rsp", {bus.o_mmu_rsp_vld, bus.o_mmu_rsp_wr, bus.o_mmu_rsp_err, bus.o_mmu_rsp_rdat}, '0);
        check_val("rst_req_rdy", bus.o_mmu_req_rdy, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        line = {{16{8'hD3}}, {16{8'hC2}}, {16{8'hB1}}, {16{8'hA0}}};
        run_txn(1'b1, 40'h1000, {MW{1'b1}}, line, 1, 0, 0, 0);
        run_txn(1'b0, 40'h2040, {MW{1'b1}}, '0, 3, 0, 0, 0);
        run_txn(1'b1, 40'h3000, 64'h00FF_00FF_F0F0_1234, {4{rand128()}}, 0, 5, 0, 0);
        run_txn(1'b0, 40'h4080, '0, '0, 2, 0, 10, 1);
        run_txn(1'b0, 40'h5000, '0, '0, 99, 0, 0, 1);
        run_txn(1'b0, 40'h5040, '0, '0, TO - 1, 0, 0, 1);
        run_txn(1'b1, 40'h6000, {MW{1'b1}}, {4{rand128()}}, 99, 0, 2, 1);
        run_txn(1'b1, 40'h6040, {MW{1'b1}}, {4{rand128()}}, TO - 1, 0, 0, 1);

        // Reset in the middle of a burst aborts the transaction outright.
        bus.i_mmu_req_vld   = 1'b1;
        bus.i_mmu_req_wr    = 1'b1;
        bus.i_mmu_req_paddr = 40'h7000;
        bus.i_mmu_req_wdat  = {4{rand128()}};
        bus.i_ext_mmu_rdy   = 1'b1;
        next_cycle();
        bus.i_mmu_req_vld = 1'b0;
        next_cycle();
        next_cycle();
        check_val("pre_rst_burst", bus.o_mem_ext_burst_vld, 1);
        rst_n = 1'b0;
        #1;
        check_mem_zero("mid_rst_mem_zero");
        check_val("mid_rst_rsp_vld", bus.o_mmu_rsp_vld, 0);
        check_val("mid_rst_req_rdy", bus.o_mmu_req_rdy, 1);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check_mem_zero("post_rst_mem_zero");
        check_val("post_rst_rsp_vld", bus.o_mmu_rsp_vld, 0);
        run_txn(1'b0, 40'h7040, '0, '0, 0, 0, 1, 0);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), PW'({$urandom, $urandom}), MW'({$urandom, $urandom}),
                    {rand128(), rand128(), rand128(), rand128()},
                    $urandom_range(0, TO + 1), $urandom_range(0, 3), $urandom_range(0, 4),
                    1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
